// File: rtl/p_sync_hs_pkg.sv
// Shared definitions for the four-phase req/ack bundled-data link.
// Used by the destination-side receiver and by the matching source-side sender.
package p_sync_hs_pkg;

    // Default bundled data width
    localparam int WIDTH_DEF     = 8;
    // Default width of the saturating protocol-error counter
    localparam int ERR_CNT_W_DEF = 8;

    // Handshake FSM states (encoding is shared with the sender)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        ACK  = 2'd2
    } hs_state_e;

endpackage : p_sync_hs_pkg

// File: rtl/p_sync_hs_rx.sv
// Destination-clock receiver for a four-phase req/ack bundled-data transfer.
// DST_REQ_S arrives already synchronized; SRC_ACK is resynchronized in the
// source domain, so nothing here is metastability hardened. All outputs are
// registered.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a request; DST_DATA keeps the last captured word
// HOLD  | captured word offered to the consumer (DST_VALID=1)
// ACK   | word handed over; SRC_ACK=1 until the request is withdrawn
module p_sync_hs_rx
    import p_sync_hs_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int ERR_CNT_W = ERR_CNT_W_DEF
) (
    input  logic                 DST_CLK,
    input  logic                 DST_RST,
    input  logic                 DST_REQ_S,
    input  logic [WIDTH-1:0]     SRC_DATA,
    output logic                 DST_VALID,
    output logic [WIDTH-1:0]     DST_DATA,
    input  logic                 DST_READY,
    output logic                 SRC_ACK,
    input  logic                 ERR_CLR,
    output logic                 ERR_STICKY,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    hs_state_e            state;
    hs_state_e            state_nxt;
    logic                 valid_nxt;
    logic                 ack_nxt;
    logic [WIDTH-1:0]     data_nxt;
    logic                 violation;

    // Next state and next registered outputs; the handover beats a
    // simultaneous request withdrawal, so the error is only raised when
    // the consumer did not take the word.
    always_comb begin
        state_nxt = state;
        valid_nxt = 1'b0;
        ack_nxt   = 1'b0;
        data_nxt  = DST_DATA;
        violation = 1'b0;
        case (state)
            IDLE: begin
                if (DST_REQ_S) begin
                    data_nxt  = SRC_DATA;
                    valid_nxt = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (DST_READY) begin
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end else if (!DST_REQ_S) begin
                    violation = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    valid_nxt = 1'b1;
                end
            end
            ACK: begin
                if (!DST_REQ_S) begin
                    state_nxt = IDLE;
                end else begin
                    ack_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and handshake output registers
    always_ff @(posedge DST_CLK) begin
        if (DST_RST) begin
            state     <= IDLE;
            DST_VALID <= 1'b0;
            DST_DATA  <= '0;
            SRC_ACK   <= 1'b0;
        end else begin
            state     <= state_nxt;
            DST_VALID <= valid_nxt;
            DST_DATA  <= data_nxt;
            SRC_ACK   <= ack_nxt;
        end
    end

    // Sticky error flag and saturating error counter; clear wins over a
    // violation in the same cycle
    always_ff @(posedge DST_CLK) begin
        if (DST_RST) begin
            ERR_STICKY <= 1'b0;
            ERR_CNT    <= '0;
        end else if (ERR_CLR) begin
            ERR_STICKY <= 1'b0;
            ERR_CNT    <= '0;
        end else if (violation) begin
            ERR_STICKY <= 1'b1;
            if (ERR_CNT != '1) begin
                ERR_CNT <= ERR_CNT + ERR_CNT_W'(1);
            end
        end
    end

endmodule : p_sync_hs_rx

// File: tb/tb_p_sync_hs_rx.sv
// Self-checking bench for p_sync_hs_rx. Two instances share all inputs: one
// with the default 8-bit error counter, one with a 2-bit counter to reach
// saturation quickly. A protocol-level model predicts every output each cycle.
module tb_p_sync_hs_rx;

    logic       clk;
    logic       rst;
    logic       req;
    logic [7:0] sdata;
    logic       ready;
    logic       clr;

    logic       valid8, ack8, sticky8;
    logic [7:0] data8, cnt8;
    logic       valid2, ack2, sticky2;
    logic [7:0] data2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    p_sync_hs_rx #(.WIDTH(8), .ERR_CNT_W(8)) dut8 (
        .DST_CLK(clk), .DST_RST(rst), .DST_REQ_S(req), .SRC_DATA(sdata),
        .DST_VALID(valid8), .DST_DATA(data8), .DST_READY(ready),
        .SRC_ACK(ack8), .ERR_CLR(clr), .ERR_STICKY(sticky8), .ERR_CNT(cnt8)
    );

    p_sync_hs_rx #(.WIDTH(8), .ERR_CNT_W(2)) dut2 (
        .DST_CLK(clk), .DST_RST(rst), .DST_REQ_S(req), .SRC_DATA(sdata),
        .DST_VALID(valid2), .DST_DATA(data2), .DST_READY(ready),
        .SRC_ACK(ack2), .ERR_CLR(clr), .ERR_STICKY(sticky2), .ERR_CNT(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Protocol model: a word waiting for the consumer, a word handed over and
    // acknowledged, or nothing in flight. Violations counted without limit.
    bit         m_started = 0;
    bit         m_waiting = 0;
    bit         m_acked   = 0;
    logic [7:0] m_data    = '0;
    bit         m_sticky  = 0;
    int         m_viol    = 0;

    always @(posedge clk) begin
        bit v;
        v = 0;
        if (rst) begin
            m_started = 1;
            m_waiting = 0;
            m_acked   = 0;
            m_data    = '0;
            m_sticky  = 0;
            m_viol    = 0;
        end else begin
            if (m_waiting) begin
                if (ready) begin
                    m_waiting = 0;
                    m_acked   = 1;
                end else if (!req) begin
                    m_waiting = 0;
                    v = 1;
                end
            end else if (m_acked) begin
                if (!req) m_acked = 0;
            end else if (req) begin
                m_waiting = 1;
                m_data    = sdata;
            end
            if (clr) begin
                m_viol   = 0;
                m_sticky = 0;
            end else if (v) begin
                m_viol++;
                m_sticky = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (m_started) begin
            chk("valid8",  valid8,  m_waiting);
            chk("data8",   data8,   m_data);
            chk("ack8",    ack8,    m_acked);
            chk("sticky8", sticky8, m_sticky);
            chk("cnt8",    cnt8,    (m_viol > 255) ? 255 : m_viol);
            chk("valid2",  valid2,  m_waiting);
            chk("data2",   data2,   m_data);
            chk("ack2",    ack2,    m_acked);
            chk("sticky2", sticky2, m_sticky);
            chk("cnt2",    cnt2,    (m_viol > 3) ? 3 : m_viol);
        end
    end

    // Advance n clock edges; return just after a falling edge
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic violate();
        req = 1; ready = 0; cyc(1);
        req = 0; cyc(1);
    endtask

    initial begin
        rst = 1; req = 0; sdata = '0; ready = 0; clr = 0;
        cyc(2);
        chk("rst_valid", valid8, 0);
        chk("rst_data",  data8,  0);
        chk("rst_ack",   ack8,   0);
        chk("rst_cnt",   cnt8,   0);
        rst = 0;
        cyc(1);

        // Basic transfer
        sdata = 8'hA5; req = 1; ready = 1;
        cyc(1);
        chk("basic_valid", valid8, 1);
        chk("basic_data",  data8,  8'hA5);
        cyc(1);
        chk("basic_ack",   ack8,   1);
        chk("basic_vlo",   valid8, 0);
        cyc(2);
        chk("basic_ackhold", ack8, 1);
        req = 0;
        cyc(1);
        chk("basic_ackdrop", ack8, 0);

        // Backpressure
        sdata = 8'h5A; req = 1; ready = 0;
        cyc(1);
        for (int i = 0; i < 10; i++) begin
            sdata = 8'(i);
            cyc(1);
            chk("bp_valid", valid8, 1);
            chk("bp_data",  data8,  8'h5A);
            chk("bp_ack",   ack8,   0);
        end
        ready = 1;
        cyc(1);
        chk("bp_ackrise", ack8, 1);
        req = 0;
        cyc(1);

        // Violation, then a clean transfer
        sdata = 8'h77; ready = 0;
        violate();
        chk("viol_sticky", sticky8, 1);
        chk("viol_cnt",    cnt8,    1);
        chk("viol_valid",  valid8,  0);
        chk("viol_ack",    ack8,    0);
        cyc(2);
        chk("viol_noack",  ack8,    0);
        sdata = 8'h3C; req = 1; ready = 1;
        cyc(1);
        chk("clean_data",  data8, 8'h3C);
        cyc(1);
        chk("clean_ack",   ack8,  1);
        req = 0;
        cyc(1);

        // Simultaneous handover and withdrawal
        sdata = 8'hC3; req = 1; ready = 0;
        cyc(1);
        ready = 1; req = 0;
        cyc(1);
        chk("sim_ack", ack8, 1);
        chk("sim_cnt", cnt8, 1);
        cyc(1);
        chk("sim_ackdrop", ack8, 0);

        // Saturation and clear
        clr = 1; cyc(1); clr = 0;
        chk("clr_cnt", cnt8, 0);
        for (int i = 0; i < 5; i++) violate();
        chk("sat_cnt2", cnt2, 3);
        chk("sat_cnt8", cnt8, 5);
        req = 1; ready = 0; cyc(1);
        req = 0; clr = 1; cyc(1); clr = 0;
        chk("clrwin_cnt2",    cnt2,    0);
        chk("clrwin_sticky2", sticky2, 0);
        chk("clrwin_cnt8",    cnt8,    0);

        // Reset mid-transfer
        sdata = 8'hE1; req = 1; ready = 1;
        cyc(2);
        chk("pre_rst_ack", ack8, 1);
        rst = 1; cyc(1);
        chk("rst_mid_ack",   ack8,   0);
        chk("rst_mid_data",  data8,  0);
        chk("rst_mid_valid", valid8, 0);
        rst = 0; req = 0; cyc(1);
        sdata = 8'h99; req = 1;
        cyc(1);
        chk("post_rst_valid", valid8, 1);
        chk("post_rst_data",  data8,  8'h99);
        cyc(1);
        req = 0;
        cyc(1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = ~req;
            if ($urandom_range(0, 3) == 0) sdata = 8'($urandom);
            ready = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 60) == 0);
            rst   = ($urandom_range(0, 250) == 0);
            cyc(1);
        end
        rst = 0; clr = 0;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_p_sync_hs_rx
